// File: rtl/tmds_gearbox.sv
// tmds_gearbox: fabric gearbox that turns NUM_CH channels of IN_W-bit TMDS
// symbols into OUT_W-bit slices per fast-clock cycle, LSB first, for
// per-channel ODDR/OSERDES primitives.
//
// Optional feature macro: TMDS_GEARBOX_BITSLIP_EN
//   defined   : per-channel bit-slip (pending flags, offsets, previous-word
//               history) is built; o_phase reports the offsets.
//   undefined : i_bitslip is ignored, offsets are 0, o_phase is 0.
//
// Ports
//   i_clk       fast clock, one slice per cycle
//   i_srst      synchronous active-high reset
//   i_pdata     NUM_CH*IN_W  parallel words, channel c at [c*IN_W +: IN_W]
//   i_valid     i_pdata is valid (only sampled in the load cycle)
//   o_ready     high in the load cycle (decoded from the slice counter)
//   i_bitslip   NUM_CH       per-channel +1-bit phase shift request pulse
//   o_sdata     NUM_CH*OUT_W output slices, channel c at [c*OUT_W +: OUT_W]
//   o_underrun  one-cycle pulse after IDLE_WORD was substituted
//   o_phase     NUM_CH*PH_W  current bit offset of each channel
module tmds_gearbox #(
  parameter int              NUM_CH    = 3,
  parameter int              IN_W      = 10,
  parameter int              OUT_W     = 2,
  parameter logic [IN_W-1:0] IDLE_WORD = 10'b1101010100,
  parameter int              PH_W      = $clog2(IN_W)
) (
  input  logic                    i_clk,
  input  logic                    i_srst,
  input  logic [NUM_CH*IN_W-1:0]  i_pdata,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [NUM_CH-1:0]       i_bitslip,
  output logic [NUM_CH*OUT_W-1:0] o_sdata,
  output logic                    o_underrun,
  output logic [NUM_CH*PH_W-1:0]  o_phase
);

  localparam int R     = IN_W / OUT_W;
  localparam int CNT_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    load;
  logic [IN_W-1:0]         c_q [NUM_CH];
  logic [IN_W-1:0]         c_d [NUM_CH];
  logic [IN_W-1:0]         win_cur [NUM_CH];
  logic [IN_W-1:0]         win_new [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] sdata_q, sdata_d;
  logic                    underrun_q, underrun_d;

  assign load    = (cnt_q == CNT_LAST);
  assign o_ready = load;

  // Counter, current-word history and output slice selection. In the load
  // cycle slice 0 is taken from the window of the word being loaded so that
  // it appears on the very next cycle.
  always_comb begin
    int unsigned sidx;
    cnt_d      = load ? '0 : cnt_q + 1'b1;
    underrun_d = load & ~i_valid;
    sdata_d    = '0;
    sidx       = load ? 0 : (int'(cnt_q) + 1) * OUT_W;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      c_d[ch] = c_q[ch];
      if (load) begin
        c_d[ch] = i_valid ? i_pdata[ch*IN_W +: IN_W] : IDLE_WORD;
      end
    end
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      if (load) begin
        sdata_d[ch*OUT_W +: OUT_W] = win_new[ch][0 +: OUT_W];
      end else begin
        sdata_d[ch*OUT_W +: OUT_W] = win_cur[ch][sidx +: OUT_W];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      cnt_q      <= CNT_LAST;
      sdata_q    <= '0;
      underrun_q <= 1'b0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        c_q[ch] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        c_q[ch] <= c_d[ch];
      end
    end
  end

`ifdef TMDS_GEARBOX_BITSLIP_EN
  logic [IN_W-1:0]        p_q   [NUM_CH];
  logic [IN_W-1:0]        p_d   [NUM_CH];
  logic [PH_W-1:0]        off_q [NUM_CH];
  logic [PH_W-1:0]        off_d [NUM_CH];
  logic [NUM_CH-1:0]      pend_q, pend_d;
  logic [NUM_CH*PH_W-1:0] phase_flat;

  // W = ({C,P} >> (IN_W - off))[IN_W-1:0]; off=0 yields C.
  function automatic logic [IN_W-1:0] win_f(input logic [IN_W-1:0] c,
                                            input logic [IN_W-1:0] p,
                                            input logic [PH_W-1:0] off);
    logic [2*IN_W-1:0] cat;
    cat = {c, p} >> (IN_W - int'(off));
    return cat[IN_W-1:0];
  endfunction

  // A slip pending at a load is applied then; a pulse in the load cycle
  // itself re-arms the flag for the following load.
  always_comb begin
    pend_d     = pend_q;
    phase_flat = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      p_d[ch]   = p_q[ch];
      off_d[ch] = off_q[ch];
      if (load) begin
        p_d[ch]    = c_q[ch];
        pend_d[ch] = i_bitslip[ch];
        if (pend_q[ch]) begin
          off_d[ch] = (off_q[ch] == PH_W'(IN_W - 1)) ? '0 : off_q[ch] + 1'b1;
        end
      end else begin
        pend_d[ch] = pend_q[ch] | i_bitslip[ch];
      end
      win_cur[ch] = win_f(c_q[ch], p_q[ch], off_q[ch]);
      win_new[ch] = win_f(c_d[ch], p_d[ch], off_d[ch]);
      phase_flat[ch*PH_W +: PH_W] = off_q[ch];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      pend_q <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        p_q[ch]   <= '0;
        off_q[ch] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        p_q[ch]   <= p_d[ch];
        off_q[ch] <= off_d[ch];
      end
    end
  end

  assign o_phase = phase_flat;
`else
  logic unused_bitslip;
  assign unused_bitslip = ^i_bitslip;

  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      win_cur[ch] = c_q[ch];
      win_new[ch] = c_d[ch];
    end
  end

  assign o_phase = '0;
`endif

  assign o_sdata    = sdata_q;
  assign o_underrun = underrun_q;

endmodule

// File: doc/tmds_gearbox.md
# tmds_gearbox

Fabric gearbox that turns NUM_CH channels of IN_W-bit TMDS symbols into OUT_W-bit slices per fast-clock cycle, LSB first. It feeds per-channel ODDR/OSERDES primitives in the HDMI transmit path. It generalises the fixed 10:1 hard-serializer path: channel count and widths are parametrised, input uses a valid/ready handshake, underruns are filled with an idle token, and optional per-channel bit-slip is supported.

## Interface
- NUM_CH, 3: number of independent channels.
- IN_W, 10: input symbol width per channel.
- OUT_W, 2: output slice width per channel per cycle. IN_W must be an integer multiple of OUT_W. R = IN_W/OUT_W.
- IDLE_WORD, 10'b1101010100: symbol inserted on underrun. Same value on every channel.
- PH_W, $clog2(IN_W): width of the per-channel phase field.
- i_clk  in  1: fast clock, one slice per cycle.
- i_srst  in  1: reset, synchronous, active-high.
- i_pdata  in  NUM_CH*IN_W: channel c occupies [c*IN_W +: IN_W].
- i_valid  in  1: i_pdata is valid.
- o_ready  out  1: gearbox accepts a word this cycle.
- i_bitslip  in  NUM_CH: one-cycle pulse per channel; request a +1-bit phase shift.
- o_sdata  out  NUM_CH*OUT_W: channel c occupies [c*OUT_W +: OUT_W]. Earlier bit is in the LSB.
- o_underrun  out  1: one-cycle pulse when IDLE_WORD is substituted.
- o_phase  out  NUM_CH*PH_W: current bit offset of each channel.

## Operation
- **Slice counter** `cnt` counts 0..R-1 and runs freely. The cycle with cnt==R-1 is the load cycle. `o_ready = (cnt==R-1)`, decoded from the register.
- **Load cycle with i_valid=1:** the word is accepted.
- **Load cycle with i_valid=0:** IDLE_WORD is loaded on all channels, and o_underrun=1 in the next cycle.
- **Outside the load cycle:** i_valid is ignored and no word is consumed.
- **Per-channel word history:** each load does P <= C, C <= new word.
  - Window W = ({C,P} >> (IN_W - off))[IN_W-1:0].
  - off=0 gives W=C. off=k delays the channel's serial stream by k bits.
- **Output:** o_sdata slice for channel c in cycle s after a load (s=0..R-1) is W_c[s*OUT_W +: OUT_W].
- **Bit-slip:**
  - A pulse on i_bitslip[c] sets a pending flag for channel c.
  - The pending flag is applied only at the next load: off_c <= (off_c==IN_W-1) ? 0 : off_c+1, and the flag clears.
  - Multiple pulses before one load collapse into a single increment.
  - A pulse arriving in the load cycle itself is counted for the following load.
  - Channels are independent.
- **o_phase** shows off_c as updated at the load.

## Timing
- **Reset** (i_srst high at a rising edge):
  - cnt=R-1, so the first cycle after reset is a load cycle and o_ready=1.
  - C=P=0, off=0, pending=0.
  - o_sdata=0, o_underrun=0, o_phase=0.
- **Latency:** for a word accepted at edge t, slice 0 appears on o_sdata in cycle t+1 and slice R-1 in cycle t+R.
- **Throughput:** one word per R cycles. A word source must present valid data when o_ready is high.
- **Reset mid-word:** the current word is abandoned immediately, and outputs go to their reset values in the next cycle.
- **Simultaneous reset and bitslip:** reset wins; pending stays 0.
- **Registers:** all outputs are registered except o_ready, which is decoded from cnt alone.

## Configuration
- **TMDS_GEARBOX_BITSLIP_EN defined:**
  - i_bitslip, the pending flags, the off registers and P history are built.
  - o_phase reports the offsets.
- **Not defined:**
  - i_bitslip is ignored and off is tied to 0.
  - W=C, with no P register.
  - o_phase is constant 0.
  - Latency and handshake are unchanged.

## Test plan
- **Reset:** i_srst high for 3 cycles, then low.
  - During reset: o_sdata=0, o_underrun=0, o_phase=0.
  - First cycle after release: o_ready=1.
- **Streaming:** drive ch0 words 10'h3FF then 10'h000 back-to-back on every o_ready.
  - ch0 slices are 2'b11 for 5 cycles, then 2'b00 for 5 cycles.
  - o_ready is high every 5th cycle.
  - o_underrun stays 0.
- **Underrun:** hold i_valid=0 across one load.
  - o_underrun pulses for one cycle.
  - All channels emit IDLE_WORD slices 00,01,01,01,11 (LSB first).
- **Bit-slip:** stream a constant 10'h001 on ch1 and pulse i_bitslip[1] once mid-word.
  - At the next load, o_phase for ch1 becomes 1.
  - The ch1 '1' bit moves from output bit position 0 to position 1; ch0 and ch2 are unchanged.
- **Offset wrap:** issue 10 bitslip pulses, one per word, on ch2.
  - o_phase for ch2 counts 1..9, then 0.
  - Two pulses within one word give a single increment.
- **Reset mid-word:** assert i_srst at slice 2.
  - Next cycle: o_sdata=0 and o_ready=1.
  - The word accepted after reset is output intact starting at slice 0.
